// File: rtl/ram_stream_bank.sv
// ram_stream_bank: per-node data RAM with a core port, a peek port, a clear engine and a stream dump engine
module ram_stream_bank #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rd_data,
  input  logic [ADDR_W-1:0]   peek_addr,
  output logic [DATA_W-1:0]   peek_data,
  input  logic                clr_start,
  input  logic                dump_start,
  input  logic [ADDR_W-1:0]   dump_base,
  input  logic [ADDR_W:0]     dump_len,
  output logic [DATA_W-1:0]   dump_data,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic                dump_last,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, CLEAR, DUMP, DRAIN} state_t;
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                hd_q, hd_d;
  logic [DATA_W-1:0]   sb_dat_q [2];
  logic [DATA_W-1:0]   sb_dat_d [2];
  logic [1:0]          sb_last_q, sb_last_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]   peek_data_q, peek_data_d;
  logic                done_q, done_d;
  logic                dumping, issue, pop, tail;
  logic [ADDR_W-1:0]   pk_addr;
  logic [DATA_W-1:0]   pk_word;
  always_comb begin
    dumping     = state_q == DUMP || state_q == DRAIN;
    pk_addr     = dumping ? ptr_q : peek_addr;
    pk_word     = mem[pk_addr];
    issue       = state_q == DUMP && cnt_q != 2'd2;
    pop         = cnt_q != 2'd0 && dump_ready;
    tail        = hd_q ^ cnt_q[0];
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    sb_dat_d    = sb_dat_q;
    sb_last_d   = sb_last_q;
    cnt_d       = cnt_q + {1'b0, issue} - {1'b0, pop};
    hd_d        = hd_q ^ pop;
    rd_data_d   = mem[addr];
    peek_data_d = dumping ? peek_data_q : pk_word;
    if (issue) begin
      sb_dat_d[tail]  = pk_word;
      sb_last_d[tail] = rem_q == (ADDR_W+1)'(1);
      ptr_d           = ptr_q + ADDR_W'(1);
      rem_d           = rem_q - (ADDR_W+1)'(1);
    end
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (dump_start) begin
          if (dump_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = DUMP;
            ptr_d   = dump_base;
            rem_d   = dump_len;
          end
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH-1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      DUMP:  state_d = (issue && rem_q == (ADDR_W+1)'(1)) ? DRAIN : DUMP;
      DRAIN: begin
        if (pop && cnt_q == 2'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      hd_q        <= 1'b0;
      sb_dat_q    <= '{default: '0};
      sb_last_q   <= '0;
      rd_data_q   <= '0;
      peek_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      hd_q        <= hd_d;
      sb_dat_q    <= sb_dat_d;
      sb_last_q   <= sb_last_d;
      rd_data_q   <= rd_data_d;
      peek_data_q <= peek_data_d;
      done_q      <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (we) begin
      for (int i = 0; i < DATA_W/8; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end
  assign rd_data    = rd_data_q;
  assign peek_data  = peek_data_q;
  assign dump_valid = cnt_q != 2'd0;
  assign dump_data  = sb_dat_q[hd_q];
  assign dump_last  = dump_valid && sb_last_q[hd_q];
  assign busy       = state_q != IDLE;
  assign done       = done_q;
endmodule

// File: tb/tb_ram_stream_bank.sv
// tb_ram_stream_bank: directed self-checking bench for ram_stream_bank (DEPTH=16)
module tb_ram_stream_bank;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          we = 1'b0;
    logic [3:0]    be = '0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] peek_addr = '0;
    logic [DW-1:0] peek_data;
    logic          clr_start = 1'b0;
    logic          dump_start = 1'b0;
    logic [AW-1:0] dump_base = '0;
    logic [AW:0]   dump_len = '0;
    logic [DW-1:0] dump_data;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic          dump_last;
    logic          busy;
    logic          done;
    int            checks = 0;
    int            errors = 0;
    ram_stream_bank #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data), .we(we), .be(be),
        .rd_data(rd_data), .peek_addr(peek_addr), .peek_data(peek_data),
        .clr_start(clr_start), .dump_start(dump_start), .dump_base(dump_base),
        .dump_len(dump_len), .dump_data(dump_data), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_last(dump_last), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wr(input int a, input logic [DW-1:0] d);
        addr = AW'(a);
        wr_data = d;
        be = 4'hf;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask
    initial begin
        int got;
        int cyc;
        int bcnt;
        tick();
        tick();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_peek_data", peek_data, 0);
        chk("rst_dump_data", dump_data, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_last", dump_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();
        addr = 4'd5;
        wr_data = 32'hAABBCCDD;
        be = 4'b0101;
        we = 1'b1;
        tick();
        we = 1'b0;
        tick();
        chk("t1_byte_enable", rd_data, 32'h00BB00DD);
        addr = 4'd7;
        wr_data = 32'h1;
        be = 4'hf;
        we = 1'b1;
        tick();
        chk("t2_read_old", rd_data, 0);
        we = 1'b0;
        tick();
        chk("t2_read_new", rd_data, 1);
        for (int i = 0; i < DEPTH; i++) wr(i, DW'(i));
        peek_addr = 4'd3;
        tick();
        chk("peek_read", peek_data, 3);
        dump_base = 4'd14;
        dump_len = 5'd4;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        peek_addr = 4'd9;
        chk("t3_busy", busy, 1);
        chk("t3_valid_early", dump_valid, 0);
        tick();
        chk("t3_v0", dump_valid, 1);
        chk("t3_d0", dump_data, 14);
        chk("t3_l0", dump_last, 0);
        tick();
        chk("t3_v1", dump_valid, 1);
        chk("t3_d1", dump_data, 15);
        chk("t3_peek_held", peek_data, 3);
        tick();
        chk("t3_v2", dump_valid, 1);
        chk("t3_d2", dump_data, 0);
        chk("t3_l2", dump_last, 0);
        tick();
        chk("t3_v3", dump_valid, 1);
        chk("t3_d3", dump_data, 1);
        chk("t3_l3", dump_last, 1);
        chk("t3_done_early", done, 0);
        tick();
        chk("t3_valid_end", dump_valid, 0);
        chk("t3_done", done, 1);
        chk("t3_busy_end", busy, 0);
        tick();
        chk("t3_done_pulse", done, 0);
        chk("t3_peek_resume", peek_data, 9);
        dump_base = 4'd0;
        dump_len = 5'd16;
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        got = 0;
        cyc = 0;
        while (got < 16 && cyc < 400) begin
            dump_ready = ($urandom_range(0, 9) < 3);
            if (dump_valid) begin
                chk("t4_data", dump_data, 64'(got));
                chk("t4_last", dump_last, 64'(got == 15));
                if (dump_ready) got++;
            end
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        chk("t4_count", 64'(got), 16);
        chk("t4_done", done, 1);
        chk("t4_valid_end", dump_valid, 0);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        addr = 4'd2;
        wr_data = 32'hDEADBEEF;
        be = 4'hf;
        we = 1'b1;
        bcnt = 0;
        while (busy && bcnt < 100) begin
            bcnt++;
            tick();
        end
        we = 1'b0;
        chk("t5_busy_cycles", 64'(bcnt), 16);
        chk("t5_done", done, 1);
        for (int i = 0; i < DEPTH; i++) begin
            addr = AW'(i);
            peek_addr = AW'(i);
            tick();
            chk("t5_cleared", rd_data, 0);
        end
        chk("t5_peek_cleared", peek_data, 0);
        wr(4, 32'h44);
        clr_start = 1'b1;
        dump_start = 1'b1;
        dump_base = 4'd4;
        dump_len = 5'd4;
        dump_ready = 1'b1;
        tick();
        clr_start = 1'b0;
        dump_start = 1'b0;
        chk("t6_busy", busy, 1);
        for (int k = 0; k < DEPTH; k++) begin
            chk("t6_no_dump", dump_valid, 0);
            tick();
        end
        chk("t6_clear_done", done, 1);
        addr = 4'd4;
        tick();
        chk("t6_word_cleared", rd_data, 0);
        tick();
        chk("t6_no_late_dump", dump_valid, 0);
        wr(9, 32'h99);
        dump_base = 4'd8;
        dump_len = 5'd8;
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        tick();
        chk("t6_mid_valid", dump_valid, 1);
        chk("t6_mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", dump_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        addr = 4'd9;
        tick();
        chk("t6_post_done", done, 0);
        chk("t6_array_kept", rd_data, 32'h99);
        dump_len = 5'd0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("t6_len0_done", done, 1);
        chk("t6_len0_valid", dump_valid, 0);
        chk("t6_len0_busy", busy, 0);
        tick();
        chk("t6_len0_pulse", done, 0);
        chk("t6_len0_no_beat", dump_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
